// File: rtl/div_unit.sv
// div_unit: multicycle restoring divider, one quotient bit per clock.
// Define DIV_UNSIGNED_EN to honour is_unsigned; otherwise all divides are signed.
module div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             is_unsigned,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic             div0,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FIX,
    ERR
  } state_t;

  state_t state;
  state_t state_nx;

  logic [CW-1:0]  cnt;
  logic [WIDTH:0] rem;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] dvs;
  logic sgn_n;
  logic sgn_d;

  logic uns;
`ifdef DIV_UNSIGNED_EN
  assign uns = is_unsigned;
`else
  logic unused_sel;
  assign unused_sel = is_unsigned;
  assign uns = 1'b0;
`endif

  logic neg_n;
  logic neg_d;
  logic [WIDTH-1:0] mag_n;
  logic [WIDTH-1:0] mag_d;
  logic div_zero;
  logic last;

  assign neg_n = !uns && dividend[WIDTH-1];
  assign neg_d = !uns && divisor[WIDTH-1];
  assign mag_n = neg_n ? -dividend : dividend;
  assign mag_d = neg_d ? -divisor : divisor;
  assign div_zero = (divisor == '0);
  assign last = (cnt == CW'(WIDTH - 1));

  logic [WIDTH:0] rem_sh;
  logic [WIDTH:0] rem_sub;
  logic [WIDTH-1:0] quo_sh;
  logic fits;

  // rem[WIDTH] is always zero between steps; folding it in keeps the
  // compare honest should that invariant ever be broken.
  always_comb begin
    rem_sh  = {rem[WIDTH-1:0], quo[WIDTH-1]};
    rem_sub = rem_sh - {1'b0, dvs};
    fits    = rem[WIDTH] || (rem_sh >= {1'b0, dvs});
    quo_sh  = {quo[WIDTH-2:0], fits};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    busy     = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          state_nx = div_zero ? ERR : RUN;
        end
      end
      RUN: begin
        busy = 1'b1;
        if (last) begin
          state_nx = FIX;
        end
      end
      FIX: begin
        busy     = 1'b1;
        state_nx = IDLE;
      end
      ERR: begin
        state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt   <= '0;
      rem   <= '0;
      quo   <= '0;
      dvs   <= '0;
      sgn_n <= 1'b0;
      sgn_d <= 1'b0;
      hi    <= '0;
      lo    <= '0;
      done  <= 1'b0;
      div0  <= 1'b0;
    end else begin
      done <= 1'b0;
      div0 <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start && div_zero) begin
            div0 <= 1'b1;
          end else if (start) begin
            rem   <= '0;
            quo   <= mag_n;
            dvs   <= mag_d;
            sgn_n <= neg_n;
            sgn_d <= neg_d;
            cnt   <= '0;
          end
        end
        RUN: begin
          rem <= fits ? rem_sub : rem_sh;
          quo <= quo_sh;
          cnt <= cnt + CW'(1);
        end
        FIX: begin
          lo   <= (sgn_n ^ sgn_d) ? -quo : quo;
          hi   <= sgn_n ? -rem[WIDTH-1:0] : rem[WIDTH-1:0];
          done <= 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

endmodule
